// File: rtl/seq_guess_auto.sv
// seq_guess_auto: sequence-entry automaton driving an 8-digit seven-segment front end.
// The user keys digits on data/load. Each digit is compared with the expected digit for
// the current step. A match advances the step; a mismatch returns to the group start.
// The left display half shows the expected digits of the current group; the right half
// shows the digits entered.
//
// Optional feature: define SEQ_GUESS_LOCKOUT_EN to enable lockout. When MAX_ERR
// consecutive mismatches occur, the step returns to 0 and the display clears.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   load, data  : entry strobe and entered digit
//   exp_idx     : index of the current step, fed to an external combinational sequence function
//   exp_val     : expected digit for exp_idx, valid in the same cycle
//   display     : {left half, right half}; the rightmost digit of each half is in the LSBs
//   display_en  : per-digit enables, same layout as display
//   done        : the whole sequence has been entered correctly
//   err_cnt     : saturating total of mismatches
module seq_guess_auto #(
   parameter int unsigned DIGIT_W = 4,
   parameter int unsigned GROUP   = 4,
   parameter int unsigned SEQ_LEN = 16,
   parameter int unsigned SHOW    = 4,
   parameter int unsigned ERR_W   = 8,
   parameter int unsigned MAX_ERR = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load,
   input  logic [DIGIT_W-1:0]            data,
   output logic [$clog2(SEQ_LEN)-1:0]    exp_idx,
   input  logic [DIGIT_W-1:0]            exp_val,
   output logic [2*SHOW*DIGIT_W-1:0]     display,
   output logic [2*SHOW-1:0]             display_en,
   output logic                          done,
   output logic [ERR_W-1:0]              err_cnt
);

   localparam int unsigned IW = $clog2(SEQ_LEN);
   localparam int unsigned SW = $clog2(SEQ_LEN + 1);
   localparam int unsigned HW = SHOW * DIGIT_W;
   localparam int unsigned CW = $clog2(MAX_ERR + 1);

   logic [SW-1:0]   r_step;
   logic            r_upd;
   logic [CW-1:0]   r_cerr;

   logic [SW-1:0]   w_step_nx;
   logic            w_upd_nx;
   logic [CW-1:0]   w_cerr_nx;
   logic [HW-1:0]   w_left_nx;
   logic [HW-1:0]   w_right_nx;
   logic [SHOW-1:0] w_len_nx;
   logic [SHOW-1:0] w_ren_nx;
   logic            w_done_nx;
   logic [ERR_W-1:0] w_err_nx;
   logic [SW-1:0]   w_grp_base;
   logic            w_grp_start;

   // Once done, the step index stays at the last valid entry.
   assign exp_idx     = done ? IW'(SEQ_LEN - 1) : r_step[IW-1:0];
   assign w_grp_base  = r_step & ~SW'(GROUP - 1);
   assign w_grp_start = (r_step & SW'(GROUP - 1)) == '0;

   // Next-state logic: refresh of the left half, then the entry.
   // An entry in the same cycle overrides the refresh's clearing of upd.
   always_comb begin
      w_step_nx  = r_step;
      w_upd_nx   = r_upd;
      w_cerr_nx  = r_cerr;
      w_left_nx  = display[2*HW-1:HW];
      w_right_nx = display[HW-1:0];
      w_len_nx   = display_en[2*SHOW-1:SHOW];
      w_ren_nx   = display_en[SHOW-1:0];
      w_done_nx  = done;
      w_err_nx   = err_cnt;

      if (!done) begin
         if (r_upd) begin
            if (w_grp_start) begin
               w_left_nx = HW'(exp_val);
               w_len_nx  = SHOW'(1);
            end else begin
               w_left_nx = (display[2*HW-1:HW] << DIGIT_W) | HW'(exp_val);
               w_len_nx  = (display_en[2*SHOW-1:SHOW] << 1) | SHOW'(1);
            end
            w_upd_nx = 1'b0;
         end

         if (load) begin
            w_right_nx = (display[HW-1:0] << DIGIT_W) | HW'(data);
            w_ren_nx   = (display_en[SHOW-1:0] << 1) | SHOW'(1);
            if (data == exp_val) begin
               w_step_nx = r_step + SW'(1);
               w_cerr_nx = '0;
               if (r_step == SW'(SEQ_LEN - 1)) begin
                  w_done_nx = 1'b1;
               end else begin
                  w_upd_nx = 1'b1;
               end
            end else begin
               w_step_nx = w_grp_base;
               w_err_nx  = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
               w_cerr_nx = (r_cerr == CW'(MAX_ERR)) ? r_cerr : r_cerr + CW'(1);
               w_upd_nx  = 1'b1;
`ifdef SEQ_GUESS_LOCKOUT_EN
               // Lockout: this mismatch reaches MAX_ERR in a row, so restart from step 0 with a blank display.
               if (r_cerr == CW'(MAX_ERR - 1)) begin
                  w_step_nx  = '0;
                  w_cerr_nx  = '0;
                  w_left_nx  = '0;
                  w_right_nx = '0;
                  w_len_nx   = '0;
                  w_ren_nx   = '0;
               end
`endif
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step     <= '0;
         r_upd      <= 1'b1;
         r_cerr     <= '0;
         display    <= '0;
         display_en <= '0;
         done       <= 1'b0;
         err_cnt    <= '0;
      end else begin
         r_step     <= w_step_nx;
         r_upd      <= w_upd_nx;
         r_cerr     <= w_cerr_nx;
         display    <= {w_left_nx, w_right_nx};
         display_en <= {w_len_nx, w_ren_nx};
         done       <= w_done_nx;
         err_cnt    <= w_err_nx;
      end
   end

endmodule

// File: doc/seq_guess_auto.md
# seq_guess_auto

Parametrised sequence-entry automaton for the board's 8-digit seven-segment front end. The user keys digits in on `data` with `load`. The block compares each digit with the expected value of the current step, advances on a match and falls back to the start of the current group on a mismatch. The left half of the display shows the expected digits of the current group; the right half shows the digits entered. It replaces the fixed 4-bit/16-step automaton and adds completion detection, an error counter and an optional lockout.

## Interface
Parameters:
- `DIGIT_W`, 4, bits per digit and per display nibble.
- `GROUP`, 4, steps per group; power of two, `GROUP <= SHOW`.
- `SEQ_LEN`, 16, total steps; multiple of `GROUP`.
- `SHOW`, 4, digits per display half.
- `ERR_W`, 8, error counter width.
- `MAX_ERR`, 3, consecutive mismatches that trigger lockout (only with the macro).

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `load`, in, 1, entry strobe; each cycle it is high counts as one entry.
- `data`, in, DIGIT_W, entered digit.
- `exp_idx`, out, IW=clog2(SEQ_LEN), index of the current step for the external combinational sequence function.
- `exp_val`, in, DIGIT_W, expected digit for `exp_idx`, valid in the same cycle.
- `display`, out reg, 2*SHOW*DIGIT_W, upper half is the left display and lower half is the right display; the right digit of each half is in the LSBs.
- `display_en`, out reg, 2*SHOW, per-digit enables, same layout.
- `done`, out reg, 1, the whole sequence has been entered correctly.
- `err_cnt`, out reg, ERR_W, saturating total of mismatches.

## Operation
- Internal state: `step` (clog2(SEQ_LEN+1) bits), `upd` refresh-pending flag, `cerr` consecutive-error counter.
- `exp_idx = step` while `step < SEQ_LEN`; `exp_idx = SEQ_LEN-1` when done.
- Refresh happens on a cycle with `upd=1` and `done=0`:
  - If `step % GROUP == 0`: left enables become one digit (`...0001`), the left LSB digit becomes `exp_val`, and the other left digits become 0.
  - Otherwise: the left digits shift left one place with `exp_val` inserted at the LSB, and the left enables shift left with a 1 inserted.
  - `upd` clears.
- Entry happens on a cycle with `load=1` and `done=0`:
  - The right digits shift left with `data` inserted, and the right enables shift left with a 1 inserted.
  - Match (`data == exp_val`): `step` increments and `cerr` clears. If the new `step == SEQ_LEN`, `done` is set and `upd` is left unchanged. Otherwise `upd` is set.
  - Mismatch: `step` goes to `step & ~(GROUP-1)`, `err_cnt` increments (saturating at all ones), `cerr` increments, and `upd` is set.
- When refresh and entry fall in the same cycle, both apply. Entry uses the `exp_val` for the pre-update `step`, and entry's setting of `upd` wins over refresh's clearing of it.
- While `done=1`: `load` is ignored, the display is frozen, and only reset leaves this state.

## Timing
- Reset values: `display=0`, `display_en=0`, `done=0`, `err_cnt=0`, `step=0`, `cerr=0`, `upd=1`.
- After `rst_n` deasserts, the first clock edge shows `exp_val(0)` on the left LSB digit with `display_en[SHOW]=1`.
- An entry is reflected on the right half at the edge where `load` is sampled.
- The left half reflects the new step one edge later (latency 1).
- `done` and `err_cnt` update at the entry edge.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously).

## Configuration
- Macro `SEQ_GUESS_LOCKOUT_EN`.
- Defined: when a mismatch makes `cerr` reach `MAX_ERR`:
  - `step` returns to 0 instead of the group start, and `cerr` clears.
  - Both halves of `display` and `display_en` clear at that edge.
  - `upd` is set, so `exp_val(0)` appears on the next edge.
  - `err_cnt` still counts the mismatch.
- Undefined: `cerr` and `MAX_ERR` have no effect; a mismatch always returns to the group start.

## Test plan
All scenarios use default parameters with the bench function `exp_val = (exp_idx*3+1) mod 16`.
- Release reset, no load -> one edge later: `display = 32'h0001_0000`, `display_en = 8'h10`, `done = 0`.
- Enter 1,4,7 correctly -> left = `h0147`, enables = `h7` (left half), right = `h0147`, `step = 3`.
- After 1,4,7, enter `F` (wrong) -> `step = 0`, `err_cnt = 1`, left = `h0001`, right = `h147F`.
- Complete all 16 correct entries -> `done = 1` at the 16th load edge; further loads leave `display` unchanged.
- Macro defined:
  - Enter 1,4,7,A to reach step 4.
  - Enter three wrong digits -> first two return to `step = 4`.
  - Third returns to `step = 0`, display all zero for one edge, then left = `h0001`, `err_cnt = 3`.
- Assert `rst_n` low during the middle of a `load` burst -> all outputs 0 immediately.
- Release reset and sustain `load` -> 256 mismatches leave `err_cnt` saturated at `h FF`.
